// File: rtl/capture_bank.sv
// Bank of CHANNELS independent WIDTH-bit sample registers with a shared
// capture discipline: track, edge-capture, one-shot or peak-hold.
module capture_bank #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [1:0]                mode,
    input  logic [CHANNELS-1:0]       enable,
    input  logic [CHANNELS-1:0]       clear,
    input  logic [CHANNELS*WIDTH-1:0] d,
    output logic [CHANNELS*WIDTH-1:0] q,
    output logic [CHANNELS-1:0]       valid,
    output logic [CHANNELS-1:0]       missed
);

    typedef enum logic [1:0] {
        MODE_TRACK   = 2'b00,
        MODE_EDGE    = 2'b01,
        MODE_ONESHOT = 2'b10,
        MODE_PEAK    = 2'b11
    } mode_e;

    typedef enum logic {
        OS_IDLE = 1'b0,
        OS_DONE = 1'b1
    } os_state_e;

    logic [WIDTH-1:0]    q_r         [CHANNELS];
    logic [WIDTH-1:0]    q_nxt_s     [CHANNELS];
    logic [WIDTH-1:0]    d_s         [CHANNELS];
    os_state_e           state_r     [CHANNELS];
    os_state_e           state_nxt_s [CHANNELS];
    logic [CHANNELS-1:0] valid_r;
    logic [CHANNELS-1:0] valid_nxt_s;
    logic [CHANNELS-1:0] missed_r;
    logic [CHANNELS-1:0] missed_nxt_s;
    logic [CHANNELS-1:0] en_prev_r;
    logic [1:0]          mode_prev_r;
    logic                mode_chg_s;

    assign mode_chg_s = (mode != mode_prev_r);

    // Split the packed data bus into per-channel words.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            d_s[i] = d[i*WIDTH +: WIDTH];
        end
    end

    // Per-channel next state: clear beats mode change beats the capture rule.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            q_nxt_s[i]      = q_r[i];
            valid_nxt_s[i]  = valid_r[i];
            missed_nxt_s[i] = missed_r[i];
            state_nxt_s[i]  = state_r[i];
            if (clear[i]) begin
                q_nxt_s[i]      = {WIDTH{1'b0}};
                valid_nxt_s[i]  = 1'b0;
                missed_nxt_s[i] = 1'b0;
                state_nxt_s[i]  = OS_IDLE;
            end else if (mode_chg_s) begin
                valid_nxt_s[i]  = 1'b0;
                missed_nxt_s[i] = 1'b0;
                state_nxt_s[i]  = OS_IDLE;
            end else begin
                case (mode)
                    MODE_TRACK: begin
                        if (enable[i]) begin
                            q_nxt_s[i]     = d_s[i];
                            valid_nxt_s[i] = 1'b1;
                        end else begin
                            q_nxt_s[i] = q_r[i];
                        end
                    end
                    MODE_EDGE: begin
                        if (enable[i] && !en_prev_r[i]) begin
                            q_nxt_s[i]     = d_s[i];
                            valid_nxt_s[i] = 1'b1;
                        end else begin
                            q_nxt_s[i] = q_r[i];
                        end
                    end
                    MODE_ONESHOT: begin
                        case (state_r[i])
                            OS_IDLE: begin
                                if (enable[i]) begin
                                    q_nxt_s[i]     = d_s[i];
                                    valid_nxt_s[i] = 1'b1;
                                    state_nxt_s[i] = OS_DONE;
                                end else begin
                                    state_nxt_s[i] = OS_IDLE;
                                end
                            end
                            OS_DONE: begin
                                if (enable[i]) begin
                                    missed_nxt_s[i] = 1'b1;
                                end else begin
                                    missed_nxt_s[i] = missed_r[i];
                                end
                            end
                            default: state_nxt_s[i] = OS_IDLE;
                        endcase
                    end
                    MODE_PEAK: begin
                        // First sample after (re)arm is taken unconditionally.
                        if (enable[i] && (!valid_r[i] || (d_s[i] > q_r[i]))) begin
                            q_nxt_s[i]     = d_s[i];
                            valid_nxt_s[i] = 1'b1;
                        end else begin
                            q_nxt_s[i] = q_r[i];
                        end
                    end
                    default: q_nxt_s[i] = q_r[i];
                endcase
            end
        end
    end

    // State registers; reset discards all held data.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                q_r[i]     <= {WIDTH{1'b0}};
                state_r[i] <= OS_IDLE;
            end
            valid_r     <= {CHANNELS{1'b0}};
            missed_r    <= {CHANNELS{1'b0}};
            en_prev_r   <= {CHANNELS{1'b0}};
            mode_prev_r <= 2'b00;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                q_r[i]     <= q_nxt_s[i];
                state_r[i] <= state_nxt_s[i];
            end
            valid_r     <= valid_nxt_s;
            missed_r    <= missed_nxt_s;
            en_prev_r   <= enable;
            mode_prev_r <= mode;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_pack
        assign q[g*WIDTH +: WIDTH] = q_r[g];
    end

    assign valid  = valid_r;
    assign missed = missed_r;

endmodule

// File: tb/tb_capture_bank.sv
// Randomised and directed check of capture_bank at three parameter points
// against a behavioural model of the capture rules.
module tb_capture_bank;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   mode;
    logic [3:0]   en0, clr0, v0, m0;
    logic [31:0]  d0, q0;
    logic [0:0]   en1, clr1, v1, m1;
    logic [0:0]   d1, q1;
    logic [7:0]   en2, clr2, v2, m2;
    logic [127:0] d2, q2;

    int checks = 0;
    int errors = 0;

    logic [15:0] mq   [3][8];
    bit          mv   [3][8];
    bit          mm   [3][8];
    bit          mdone[3][8];
    bit          mep  [3][8];
    logic [1:0]  mmp  [3];

    always #5 clk = ~clk;

    capture_bank #(.WIDTH(8), .CHANNELS(4)) dut0 (
        .clk(clk), .rst(rst), .mode(mode), .enable(en0), .clear(clr0),
        .d(d0), .q(q0), .valid(v0), .missed(m0));
    capture_bank #(.WIDTH(1), .CHANNELS(1)) dut1 (
        .clk(clk), .rst(rst), .mode(mode), .enable(en1), .clear(clr1),
        .d(d1), .q(q1), .valid(v1), .missed(m1));
    capture_bank #(.WIDTH(16), .CHANNELS(8)) dut2 (
        .clk(clk), .rst(rst), .mode(mode), .enable(en2), .clear(clr2),
        .d(d2), .q(q2), .valid(v2), .missed(m2));

    task automatic check_value(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Apply one clock of the capture rules to model instance k.
    task automatic model_step(input int k, input int w, input int c, input logic [7:0] en,
                              input logic [7:0] clr, input logic [127:0] dv);
        logic [15:0] msk;
        logic [15:0] dd;
        bit          chg;
        if (rst) begin
            for (int ch = 0; ch < 8; ch++) begin
                mq[k][ch] = 16'h0000; mv[k][ch] = 1'b0; mm[k][ch] = 1'b0;
                mdone[k][ch] = 1'b0; mep[k][ch] = 1'b0;
            end
            mmp[k] = 2'b00;
            return;
        end
        msk = 16'((17'd1 << w) - 17'd1);
        chg = (mode != mmp[k]);
        for (int ch = 0; ch < c; ch++) begin
            dd = 16'(dv >> (ch * w)) & msk;
            if (clr[ch]) begin
                mq[k][ch] = 16'h0000; mv[k][ch] = 1'b0; mm[k][ch] = 1'b0; mdone[k][ch] = 1'b0;
            end else if (chg) begin
                mv[k][ch] = 1'b0; mm[k][ch] = 1'b0; mdone[k][ch] = 1'b0;
            end else if (en[ch]) begin
                case (mode)
                    2'b00: begin mq[k][ch] = dd; mv[k][ch] = 1'b1; end
                    2'b01: if (!mep[k][ch]) begin mq[k][ch] = dd; mv[k][ch] = 1'b1; end
                    2'b10: if (mdone[k][ch]) mm[k][ch] = 1'b1;
                           else begin mq[k][ch] = dd; mv[k][ch] = 1'b1; mdone[k][ch] = 1'b1; end
                    default: if (!mv[k][ch] || dd > mq[k][ch]) begin mq[k][ch] = dd; mv[k][ch] = 1'b1; end
                endcase
            end
            mep[k][ch] = en[ch];
        end
        mmp[k] = mode;
    endtask

    task automatic compare_all();
        logic [127:0] eq;
        logic [7:0]   ev, em;
        int           w, c;
        for (int k = 0; k < 3; k++) begin
            w = (k == 0) ? 8 : (k == 1) ? 1 : 16;
            c = (k == 0) ? 4 : (k == 1) ? 1 : 8;
            eq = 128'd0; ev = 8'd0; em = 8'd0;
            for (int ch = 0; ch < c; ch++) begin
                eq = eq | (128'(mq[k][ch]) << (ch * w));
                ev[ch] = mv[k][ch];
                em[ch] = mm[k][ch];
            end
            case (k)
                0: begin
                    check_value("q0", 128'(q0), eq);
                    check_value("valid0", 128'(v0), 128'(ev));
                    check_value("missed0", 128'(m0), 128'(em));
                end
                1: begin
                    check_value("q1", 128'(q1), eq);
                    check_value("valid1", 128'(v1), 128'(ev));
                    check_value("missed1", 128'(m1), 128'(em));
                end
                default: begin
                    check_value("q2", q2, eq);
                    check_value("valid2", 128'(v2), 128'(ev));
                    check_value("missed2", 128'(m2), 128'(em));
                end
            endcase
        end
    endtask

    task automatic step();
        model_step(0, 8, 4, 8'(en0), 8'(clr0), 128'(d0));
        model_step(1, 1, 1, 8'(en1), 8'(clr1), 128'(d1));
        model_step(2, 16, 8, en2, clr2, d2);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle_inputs();
        en0 = 4'h0; clr0 = 4'h0; en1 = 1'b0; clr1 = 1'b0; en2 = 8'h00; clr2 = 8'h00;
    endtask

    initial begin
        logic [7:0] seq_d [6];
        logic [7:0] seq_q [6];
        seq_d = '{8'h10, 8'h40, 8'h20, 8'h40, 8'hFF, 8'h00};
        seq_q = '{8'h10, 8'h40, 8'h40, 8'h40, 8'hFF, 8'hFF};

        rst = 1'b1; mode = 2'b00; idle_inputs();
        d0 = 32'h0; d1 = 1'b0; d2 = 128'h0;
        step(); step();
        check_value("rst_q0", 128'(q0), 128'd0);
        check_value("rst_valid0", 128'(v0), 128'd0);

        // TRACK
        rst = 1'b0; en0 = 4'b0001;
        d0[7:0] = 8'h11; step(); check_value("track_11", 128'(q0[7:0]), 128'(8'h11));
        d0[7:0] = 8'h22; step(); check_value("track_22", 128'(q0[7:0]), 128'(8'h22));
        d0[7:0] = 8'h33; step(); check_value("track_33", 128'(q0[7:0]), 128'(8'h33));
        en0 = 4'b0000; d0[7:0] = 8'h44; step();
        check_value("track_hold", 128'(q0[7:0]), 128'(8'h33));
        en2 = 8'h80; d2[127:112] = 16'hBEEF; step();
        check_value("pack_ch7", 128'(q2[127:112]), 128'(16'hBEEF));
        idle_inputs();

        // EDGE
        mode = 2'b01; step();
        en0 = 4'b0010;
        for (int i = 0; i < 4; i++) begin
            d0[15:8] = 8'hA0 + 8'(i); step();
        end
        check_value("edge_first", 128'(q0[15:8]), 128'(8'hA0));
        en0 = 4'b0000; step();
        en0 = 4'b0010; d0[15:8] = 8'hB5; step();
        check_value("edge_rearm", 128'(q0[15:8]), 128'(8'hB5));
        idle_inputs();

        // ONESHOT
        mode = 2'b10; step();
        en0 = 4'b0100; d0[23:16] = 8'h5C; step(); en0 = 4'b0000; step();
        check_value("os_cap", 128'(q0[23:16]), 128'(8'h5C));
        check_value("os_valid", 128'(v0[2]), 128'(1'b1));
        en0 = 4'b0100; d0[23:16] = 8'h77; step(); en0 = 4'b0000; step();
        check_value("os_hold", 128'(q0[23:16]), 128'(8'h5C));
        check_value("os_missed", 128'(m0[2]), 128'(1'b1));
        clr0 = 4'b0100; step(); clr0 = 4'b0000;
        check_value("os_clr_q", 128'(q0[23:16]), 128'd0);
        check_value("os_clr_flags", 128'({v0[2], m0[2]}), 128'd0);
        en0 = 4'b0100; step(); en0 = 4'b0000;
        check_value("os_recap", 128'(q0[23:16]), 128'(8'h77));

        // PEAK
        mode = 2'b11; step();
        en0 = 4'b1000;
        for (int i = 0; i < 6; i++) begin
            d0[31:24] = seq_d[i]; step();
            check_value($sformatf("peak_%0d", i), 128'(q0[31:24]), 128'(seq_q[i]));
        end
        en0 = 4'b0000; en2 = 8'h80;
        d2[127:112] = 16'h7FFF; step();
        d2[127:112] = 16'h8000; step();
        d2[127:112] = 16'h7FFF; step();
        check_value("peak_w16", 128'(q2[127:112]), 128'(16'h8000));
        idle_inputs();

        // Clear, capture request and mode change together
        mode = 2'b00; clr0 = 4'b0001; en0 = 4'b0010; d0[15:8] = 8'hC3; step();
        check_value("prio_q0", 128'(q0[7:0]), 128'd0);
        check_value("prio_q1", 128'(q0[15:8]), 128'(8'hB5));
        check_value("prio_valid", 128'(v0), 128'd0);
        rst = 1'b1; en0 = 4'hF; clr0 = 4'hF; en2 = 8'hFF; step();
        check_value("rst_all", 128'({q0, v0, m0}), 128'd0);
        rst = 1'b0; idle_inputs(); step();

        // Random phase
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
            en0 = 4'($urandom); clr0 = 4'($urandom & $urandom & $urandom);
            en1 = 1'($urandom); clr1 = 1'($urandom_range(0, 15) == 0);
            en2 = 8'($urandom); clr2 = 8'($urandom & $urandom & $urandom);
            d0 = $urandom; d1 = 1'($urandom);
            d2 = {$urandom, $urandom, $urandom, $urandom};
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
